// File: rtl/hangman_round_ctrl.sv
// Round sequencer for the hangman game: word entry, gallows, guess/compare loop, blank fill, body parts, scoring.
// Define ROUND_TIMER_EN to build the per-guess timer and the S_TIMEOUT path.
module hangman_round_ctrl #(
    parameter int MAX_MISSES  = 6,
    parameter int TURN_CYCLES = 50000000,
    parameter int SCORE_W     = 4
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               load,
    input  logic               endinput,
    input  logic               start,
    input  logic               try,
    input  logic               wipe,
    input  logic               graph_loaded,
    input  logic               match,
    input  logic               filled,
    input  logic               word_done,
    input  logic               finish,
    output logic               ld,
    output logic               ld_g,
    output logic               compare,
    output logic               fill,
    output logic               draw,
    output logic               plot,
    output logic               over,
    output logic               timecount,
    output logic [3:0]         part,
    output logic               setter,
    output logic [SCORE_W-1:0] p1score,
    output logic [SCORE_W-1:0] p2score
);

    typedef enum logic [3:0] {
        S_LOAD_C, S_WAIT_C, S_LOAD_GRAPH, S_WAIT_GRAPH, S_GUESS, S_EVAL, S_FILL,
        S_FILL_WAIT, S_DRAW, S_DRAW_WAIT, S_WIN, S_LOSE, S_TIMEOUT
    } state_t;

    localparam logic [3:0]         PART_LIMIT = 4'(MAX_MISSES);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};

    state_t             state_q, state_d;
    logic [3:0]         part_q;
    logic               setter_q;
    logic [SCORE_W-1:0] p1_q, p2_q;
    logic               ld_q, ld_g_q, compare_q, fill_q, draw_q, plot_q;
    logic               in_end, enter_win, enter_loss;

`ifdef ROUND_TIMER_EN
    localparam int            TW         = $clog2(TURN_CYCLES);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TURN_CYCLES - 1);
    logic [TW-1:0] timer_q;
    logic          timecount_q;
    assign timecount = timecount_q;
`else
    // Turn length is meaningless without the timer.
    logic unused_turn_cfg;
    assign unused_turn_cfg = (TURN_CYCLES > 1);
    assign timecount       = 1'b0;
`endif

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (s == SCORE_MAX) ? s : s + SCORE_W'(1);
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD_C: begin
                if (load)          state_d = S_WAIT_C;
                else if (endinput) state_d = S_LOAD_GRAPH;
            end
            S_WAIT_C:     if (!load)        state_d = S_LOAD_C;
            S_LOAD_GRAPH: if (start)        state_d = S_WAIT_GRAPH;
            S_WAIT_GRAPH: if (graph_loaded) state_d = S_GUESS;
            S_GUESS: begin
                if (try) state_d = S_EVAL;
`ifdef ROUND_TIMER_EN
                else if (timer_q == '0) state_d = S_TIMEOUT;
`endif
            end
            S_EVAL:      state_d = match ? S_FILL : S_DRAW;
            S_FILL:      if (filled) state_d = S_FILL_WAIT;
            S_FILL_WAIT: state_d = word_done ? S_WIN : S_GUESS;
            S_DRAW:      if (finish) state_d = S_DRAW_WAIT;
            S_DRAW_WAIT: state_d = (part_q == PART_LIMIT) ? S_LOSE : S_GUESS;
`ifdef ROUND_TIMER_EN
            S_WIN, S_LOSE, S_TIMEOUT: if (wipe) state_d = S_LOAD_C;
`else
            S_WIN, S_LOSE: if (wipe) state_d = S_LOAD_C;
`endif
            default: state_d = S_LOAD_C;
        endcase
    end

    assign in_end     = (state_q == S_WIN) || (state_q == S_LOSE) || (state_q == S_TIMEOUT);
    assign enter_win  = (state_q != S_WIN) && (state_d == S_WIN);
    assign enter_loss = (state_q != state_d) && ((state_d == S_LOSE) || (state_d == S_TIMEOUT));

    // Strobes are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_LOAD_C;
            part_q    <= '0;
            setter_q  <= 1'b0;
            p1_q      <= '0;
            p2_q      <= '0;
            ld_q      <= 1'b0;
            ld_g_q    <= 1'b0;
            compare_q <= 1'b0;
            fill_q    <= 1'b0;
            draw_q    <= 1'b0;
            plot_q    <= 1'b0;
`ifdef ROUND_TIMER_EN
            timer_q     <= TIMER_LOAD;
            timecount_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ld_q      <= (state_d == S_LOAD_C);
            ld_g_q    <= (state_d == S_LOAD_GRAPH);
            compare_q <= (state_d == S_GUESS);
            fill_q    <= (state_d == S_FILL);
            draw_q    <= (state_d == S_DRAW);
            plot_q    <= (state_d inside {S_LOAD_C, S_LOAD_GRAPH, S_FILL, S_DRAW, S_WIN, S_LOSE, S_TIMEOUT});
            if (state_q == S_EVAL && !match) part_q <= part_q + 4'd1;
            if (in_end && wipe) begin
                part_q   <= '0;
                setter_q <= ~setter_q;
            end
            // setter=0: P1 sets the word and P2 guesses.
            if (enter_win) begin
                if (setter_q) p1_q <= sat_inc(p1_q);
                else          p2_q <= sat_inc(p2_q);
            end
            if (enter_loss) begin
                if (setter_q) p2_q <= sat_inc(p2_q);
                else          p1_q <= sat_inc(p1_q);
            end
`ifdef ROUND_TIMER_EN
            timecount_q <= (state_d == S_GUESS);
            if (state_q != S_GUESS && state_d == S_GUESS) timer_q <= TIMER_LOAD;
            else if (state_q == S_GUESS && timer_q != '0)  timer_q <= timer_q - TW'(1);
`endif
        end
    end

    assign over    = in_end && wipe;
    assign ld      = ld_q;
    assign ld_g    = ld_g_q;
    assign compare = compare_q;
    assign fill    = fill_q;
    assign draw    = draw_q;
    assign plot    = plot_q;
    assign part    = part_q;
    assign setter  = setter_q;
    assign p1score = p1_q;
    assign p2score = p2_q;

endmodule

// File: tb/tb_hangman_round_ctrl.sv
// Randomized bench for hangman_round_ctrl against a round-level score/part model.
module tb_hangman_round_ctrl;
    localparam int MAXM = 6;
    localparam int TURN = 20;
    localparam int SW   = 2;
    localparam int SMAX = 3;

    // {ld, ld_g, compare, fill, draw, plot, timecount}
`ifdef ROUND_TIMER_EN
    localparam logic [6:0] O_GUESS = 7'b0010001;
`else
    localparam logic [6:0] O_GUESS = 7'b0010000;
`endif
    localparam logic [6:0] O_LOADC = 7'b1000010;
    localparam logic [6:0] O_LOADG = 7'b0100010;
    localparam logic [6:0] O_FILL  = 7'b0001010;
    localparam logic [6:0] O_DRAW  = 7'b0000110;
    localparam logic [6:0] O_END   = 7'b0000010;
    localparam logic [6:0] O_IDLE  = 7'b0000000;

    logic clk = 1'b0;
    logic resetn = 1'b1;
    logic load = 0, endinput = 0, start = 0, try = 0, wipe = 0;
    logic graph_loaded = 0, match = 0, filled = 0, word_done = 0, finish = 0;
    logic ld, ld_g, compare, fill, draw, plot, over, timecount, setter;
    logic [3:0] part;
    logic [SW-1:0] p1score, p2score;

    hangman_round_ctrl #(.MAX_MISSES(MAXM), .TURN_CYCLES(TURN), .SCORE_W(SW)) dut (
        .clk(clk), .resetn(resetn), .load(load), .endinput(endinput), .start(start), .try(try),
        .wipe(wipe), .graph_loaded(graph_loaded), .match(match), .filled(filled),
        .word_done(word_done), .finish(finish), .ld(ld), .ld_g(ld_g), .compare(compare),
        .fill(fill), .draw(draw), .plot(plot), .over(over), .timecount(timecount),
        .part(part), .setter(setter), .p1score(p1score), .p2score(p2score)
    );

    always #5 clk = ~clk;

    logic [16:0] snap;
    assign snap = {ld, ld_g, compare, fill, draw, plot, timecount, over, part, setter, p1score, p2score};

    int nvec = 0;
    int nerr = 0;
    int m_part = 0, m_setter = 0, m_p1 = 0, m_p2 = 0;

    function automatic int inc_sat(input int s);
        return (s >= SMAX) ? SMAX : s + 1;
    endfunction

    function automatic logic [16:0] want(input logic [6:0] o, input logic ov);
        return {o, ov, 4'(m_part), 1'(m_setter), SW'(m_p1), SW'(m_p2)};
    endfunction

    task automatic model_guesser_scores();
        if (m_setter == 0) m_p2 = inc_sat(m_p2);
        else               m_p1 = inc_sat(m_p1);
    endtask

    task automatic model_setter_scores();
        if (m_setter == 0) m_p1 = inc_sat(m_p1);
        else               m_p2 = inc_sat(m_p2);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_setup();
        int letters;
        letters = $urandom_range(1, 5);
        for (int l = 0; l < letters; l++) begin
            load = 1'b1;
            endinput = 1'($urandom_range(0, 1));
            tick();
            nvec++; if (snap !== want(O_IDLE, 1'b0)) begin nerr++; $display("FAIL wait_c: got %b want %b", snap, want(O_IDLE, 1'b0)); end
            repeat ($urandom_range(0, 2)) begin
                tick();
                nvec++; if (snap !== want(O_IDLE, 1'b0)) begin nerr++; $display("FAIL wait_c_hold: got %b want %b", snap, want(O_IDLE, 1'b0)); end
            end
            load = 1'b0;
            endinput = 1'b0;
            tick();
            nvec++; if (snap !== want(O_LOADC, 1'b0)) begin nerr++; $display("FAIL load_c: got %b want %b", snap, want(O_LOADC, 1'b0)); end
        end
        endinput = 1'b1;
        tick();
        endinput = 1'b0;
        nvec++; if (snap !== want(O_LOADG, 1'b0)) begin nerr++; $display("FAIL load_graph: got %b want %b", snap, want(O_LOADG, 1'b0)); end
        repeat ($urandom_range(0, 2)) begin
            try = 1'b1;
            tick();
            try = 1'b0;
            nvec++; if (snap !== want(O_LOADG, 1'b0)) begin nerr++; $display("FAIL load_graph_try: got %b want %b", snap, want(O_LOADG, 1'b0)); end
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        nvec++; if (snap !== want(O_IDLE, 1'b0)) begin nerr++; $display("FAIL wait_graph: got %b want %b", snap, want(O_IDLE, 1'b0)); end
        repeat ($urandom_range(0, 2)) begin
            tick();
            nvec++; if (snap !== want(O_IDLE, 1'b0)) begin nerr++; $display("FAIL wait_graph_hold: got %b want %b", snap, want(O_IDLE, 1'b0)); end
        end
        graph_loaded = 1'b1;
        tick();
        graph_loaded = 1'b0;
        nvec++; if (snap !== want(O_GUESS, 1'b0)) begin nerr++; $display("FAIL guess_entry: got %b want %b", snap, want(O_GUESS, 1'b0)); end
    endtask

    // One guess from S_GUESS: idle cycles without try, then a try resolved as hit/miss.
    task automatic do_guess(input int idle, input bit hit, input bit done, output bit ended);
        ended = 1'b0;
        for (int i = 0; i < idle; i++) begin
            tick();
`ifdef ROUND_TIMER_EN
            if (i == TURN - 1) begin
                model_setter_scores();
                ended = 1'b1;
                nvec++; if (snap !== want(O_END, 1'b0)) begin nerr++; $display("FAIL timeout: got %b want %b", snap, want(O_END, 1'b0)); end
                return;
            end
`endif
            nvec++; if (snap !== want(O_GUESS, 1'b0)) begin nerr++; $display("FAIL guess_idle: got %b want %b", snap, want(O_GUESS, 1'b0)); end
        end
        try = 1'b1;
        tick();
        try = 1'b0;
        nvec++; if (snap !== want(O_IDLE, 1'b0)) begin nerr++; $display("FAIL eval: got %b want %b", snap, want(O_IDLE, 1'b0)); end
        match = hit;
        tick();
        match = 1'b0;
        if (hit) begin
            nvec++; if (snap !== want(O_FILL, 1'b0)) begin nerr++; $display("FAIL fill: got %b want %b", snap, want(O_FILL, 1'b0)); end
            repeat ($urandom_range(0, 2)) begin
                try = 1'($urandom_range(0, 1));
                tick();
                try = 1'b0;
                nvec++; if (snap !== want(O_FILL, 1'b0)) begin nerr++; $display("FAIL fill_hold: got %b want %b", snap, want(O_FILL, 1'b0)); end
            end
            filled = 1'b1;
            tick();
            filled = 1'b0;
            nvec++; if (snap !== want(O_IDLE, 1'b0)) begin nerr++; $display("FAIL fill_wait: got %b want %b", snap, want(O_IDLE, 1'b0)); end
            word_done = done;
            tick();
            word_done = 1'b0;
            if (done) begin
                model_guesser_scores();
                ended = 1'b1;
                nvec++; if (snap !== want(O_END, 1'b0)) begin nerr++; $display("FAIL win: got %b want %b", snap, want(O_END, 1'b0)); end
            end else begin
                nvec++; if (snap !== want(O_GUESS, 1'b0)) begin nerr++; $display("FAIL guess_after_fill: got %b want %b", snap, want(O_GUESS, 1'b0)); end
            end
        end else begin
            m_part++;
            nvec++; if (snap !== want(O_DRAW, 1'b0)) begin nerr++; $display("FAIL draw: got %b want %b", snap, want(O_DRAW, 1'b0)); end
            repeat ($urandom_range(0, 2)) begin
                try = 1'($urandom_range(0, 1));
                tick();
                try = 1'b0;
                nvec++; if (snap !== want(O_DRAW, 1'b0)) begin nerr++; $display("FAIL draw_hold: got %b want %b", snap, want(O_DRAW, 1'b0)); end
            end
            finish = 1'b1;
            tick();
            finish = 1'b0;
            nvec++; if (snap !== want(O_IDLE, 1'b0)) begin nerr++; $display("FAIL draw_wait: got %b want %b", snap, want(O_IDLE, 1'b0)); end
            tick();
            if (m_part == MAXM) begin
                model_setter_scores();
                ended = 1'b1;
                nvec++; if (snap !== want(O_END, 1'b0)) begin nerr++; $display("FAIL lose: got %b want %b", snap, want(O_END, 1'b0)); end
            end else begin
                nvec++; if (snap !== want(O_GUESS, 1'b0)) begin nerr++; $display("FAIL guess_after_draw: got %b want %b", snap, want(O_GUESS, 1'b0)); end
            end
        end
    endtask

    task automatic do_wipe();
        repeat ($urandom_range(0, 2)) begin
            tick();
            nvec++; if (snap !== want(O_END, 1'b0)) begin nerr++; $display("FAIL end_hold: got %b want %b", snap, want(O_END, 1'b0)); end
        end
        wipe = 1'b1;
        #1;
        nvec++; if (snap !== want(O_END, 1'b1)) begin nerr++; $display("FAIL over: got %b want %b", snap, want(O_END, 1'b1)); end
        tick();
        wipe = 1'b0;
        m_part = 0;
        m_setter = 1 - m_setter;
        nvec++; if (snap !== want(O_LOADC, 1'b0)) begin nerr++; $display("FAIL after_wipe: got %b want %b", snap, want(O_LOADC, 1'b0)); end
    endtask

    task automatic test_reset();
        #3;
        resetn = 1'b0;
        load = 1'b1; start = 1'b1; try = 1'b1; wipe = 1'b1;
        m_part = 0; m_setter = 0; m_p1 = 0; m_p2 = 0;
        repeat (2) begin
            tick();
            nvec++; if (snap !== want(O_IDLE, 1'b0)) begin nerr++; $display("FAIL reset_state: got %b want %b", snap, want(O_IDLE, 1'b0)); end
        end
        load = 1'b0; start = 1'b0; try = 1'b0; wipe = 1'b0;
        resetn = 1'b1;
        tick();
        nvec++; if (snap !== want(O_LOADC, 1'b0)) begin nerr++; $display("FAIL reset_exit: got %b want %b", snap, want(O_LOADC, 1'b0)); end
    endtask

    task automatic test_win();
        bit e;
        do_setup();
        do_guess($urandom_range(0, 3), 1'b1, 1'b0, e);
        do_guess($urandom_range(0, 3), 1'b1, 1'b0, e);
        do_guess($urandom_range(0, 3), 1'b1, 1'b1, e);
        nvec++; if (e !== 1'b1) begin nerr++; $display("FAIL win_ended: got %b want 1", e); end
        do_wipe();
    endtask

    task automatic test_lose();
        bit e;
        do_setup();
        for (int g = 0; g < MAXM; g++) do_guess($urandom_range(0, 3), 1'b0, 1'b0, e);
        nvec++; if (e !== 1'b1) begin nerr++; $display("FAIL lose_ended: got %b want 1", e); end
        do_wipe();
    endtask

    task automatic test_timer();
        bit e;
        do_setup();
        do_guess(2, 1'b1, 1'b0, e);
        do_guess(3 * TURN, 1'b0, 1'b0, e);
`ifdef ROUND_TIMER_EN
        nvec++; if (e !== 1'b1) begin nerr++; $display("FAIL timeout_ended: got %b want 1", e); end
`else
        do_guess(0, 1'b1, 1'b1, e);
`endif
        do_wipe();
        do_setup();
        do_guess(TURN - 1, 1'b1, 1'b1, e);
        do_wipe();
    endtask

    task automatic test_saturation();
        bit e;
        for (int r = 0; r < 6; r++) begin
            do_setup();
            do_guess($urandom_range(0, 2), 1'b1, 1'b1, e);
            do_wipe();
        end
        for (int r = 0; r < 3; r++) begin
            do_setup();
            for (int g = 0; g < MAXM; g++) do_guess(0, 1'b0, 1'b0, e);
            do_wipe();
        end
    endtask

    task automatic test_random_rounds();
        bit e, hit, done;
        int idle;
        for (int r = 0; r < 10; r++) begin
            do_setup();
            e = 1'b0;
            for (int g = 0; !e; g++) begin
                hit  = (g >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
                done = hit && ((g >= 20) || ($urandom_range(0, 3) == 0));
                idle = ($urandom_range(0, 9) == 0) ? TURN + 1 : int'($urandom_range(0, 4));
                do_guess(idle, hit, done, e);
            end
            do_wipe();
        end
    endtask

    task automatic test_async_reset();
        do_setup();
        try = 1'b1;
        tick();
        try = 1'b0;
        match = 1'b0;
        tick();
        m_part++;
        nvec++; if (snap !== want(O_DRAW, 1'b0)) begin nerr++; $display("FAIL pre_reset_draw: got %b want %b", snap, want(O_DRAW, 1'b0)); end
        #2;
        resetn = 1'b0;
        #1;
        m_part = 0; m_setter = 0; m_p1 = 0; m_p2 = 0;
        nvec++; if (snap !== want(O_IDLE, 1'b0)) begin nerr++; $display("FAIL async_reset: got %b want %b", snap, want(O_IDLE, 1'b0)); end
        tick();
        resetn = 1'b1;
        tick();
        nvec++; if (snap !== want(O_LOADC, 1'b0)) begin nerr++; $display("FAIL async_reset_exit: got %b want %b", snap, want(O_LOADC, 1'b0)); end
    endtask

    initial begin
        test_reset();
        test_win();
        test_lose();
        test_timer();
        test_saturation();
        test_random_rounds();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: run still active at %0t, required completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
